uart_rx: RTL and testbench

Serial receiver that sits directly downstream of `UartTx`, consuming its `serial_o` line. It recovers one 8-bit character per frame (start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits) and presents it with a single-cycle valid strobe. Its frame configuration inputs mirror the transmitter's, so a TX→RX loopback with identical settings is lossless.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync.sv | 37 +++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   DATA_BITS  - character width carried by one frame
//   DIV_W      - width of the bit-period divider input
//   rx_state_e - receiver frame-tracking states
//   parity_bit - parity bit value for a character (even: XOR, odd: XNOR)
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int DIV_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 even);
    return even ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous serial line, plus a
// registered falling-edge pulse.
//   clock_i  - system clock
//   reset_ni - asynchronous active-low reset; both sync flops reset to 1
//              (line idle level)
//   async_i  - asynchronous input line
//   sync_o   - synchronized line value (two flops behind async_i)
//   fall_o   - one-cycle pulse, high in the same cycle that sync_o first
//              shows a 1->0 transition
module uart_sync (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta;
  logic sync;

  // sync is the previous value of meta, so comparing the pair flags the
  // edge one flop early; registering it aligns the pulse with sync_o.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      fall_o <= 1'b0;
    end else begin
      meta   <= async_i;
      sync   <= meta;
      fall_o <= sync & ~meta;
    end
  end

  assign sync_o = sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, one 8-bit character per frame
// (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
//   clock_i          - system clock
//   reset_ni         - asynchronous active-low reset; aborts any frame
//   serial_i         - asynchronous serial line, idles high
//   two_stop_bits_i  - 1: frame has two stop bits
//   parity_bit_i     - 1: frame carries a parity bit
//   parity_even_i    - 1: even parity, 0: odd parity
//   clock_divider_i  - bit period is divider+1 clocks (0 behaves as 1)
//   data_o           - last received character, held between frames
//   valid_o          - one-cycle strobe at frame completion
//   parity_error_o   - parity mismatch, qualified by valid_o
//   framing_error_o  - a stop bit sampled low, qualified by valid_o
//   busy_o           - high from start-edge detection to frame completion
module uart_rx
  import uart_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 serial_i,
  input  logic                 two_stop_bits_i,
  input  logic                 parity_bit_i,
  input  logic                 parity_even_i,
  input  logic [DIV_W-1:0]     clock_divider_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_error_o,
  output logic                 framing_error_o,
  output logic                 busy_o
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  logic                 rx_line;
  logic                 rx_fall;
  rx_state_e            state;
  rx_state_e            state_next;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div_q;
  logic                 two_stop_q;
  logic                 par_en_q;
  logic                 par_even_q;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err;
  logic                 frm_err;
  logic                 sample;
  logic                 start_frame;
  logic                 complete;

  uart_sync u_sync (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .async_i  (serial_i),
    .sync_o   (rx_line),
    .fall_o   (rx_fall)
  );

  // ---- state register ----
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state <= ST_IDLE;
    else           state <= state_next;
  end

  // ---- next-state logic ----
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (rx_fall) state_next = ST_START;
      ST_START:  if (sample)  state_next = rx_line ? ST_IDLE : ST_DATA;
      ST_DATA:   if (sample && idx == LAST_IDX)
                   state_next = par_en_q ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (sample)  state_next = ST_STOP1;
      ST_STOP1:  if (sample)  state_next = two_stop_q ? ST_STOP2 : ST_IDLE;
      ST_STOP2:  if (sample)  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---- decoded strobes ----
  always_comb begin
    sample      = (state != ST_IDLE) && (cnt == '0);
    start_frame = (state == ST_IDLE) && rx_fall;
    complete    = sample && (((state == ST_STOP1) && !two_stop_q) ||
                             (state == ST_STOP2));
    busy_o      = (state != ST_IDLE);
  end

  // ---- frame configuration and shift register (data path, no reset) ----
  // Configuration is captured at the start edge so changes mid-frame are
  // ignored.
  always_ff @(posedge clock_i) begin
    if (start_frame) begin
      div_q      <= clamp_div(clock_divider_i);
      two_stop_q <= two_stop_bits_i;
      par_en_q   <= parity_bit_i;
      par_even_q <= parity_even_i;
    end
    if (sample && state == ST_DATA) shift_q[idx] <= rx_line;
  end

  // ---- bit timing, error tracking and output registers ----
  // The counter is first loaded with half a bit period so every sample,
  // including the start bit, lands near mid-bit.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt             <= '0;
      idx             <= '0;
      par_err         <= 1'b0;
      frm_err         <= 1'b0;
      data_o          <= '0;
      valid_o         <= 1'b0;
      parity_error_o  <= 1'b0;
      framing_error_o <= 1'b0;
    end else begin
      if (start_frame)
        cnt <= clamp_div(clock_divider_i) >> 1;
      else if (state != ST_IDLE)
        cnt <= sample ? div_q : cnt - DIV_W'(1);

      if (sample && state == ST_START)     idx <= '0;
      else if (sample && state == ST_DATA) idx <= idx + IDX_W'(1);

      if (start_frame)
        par_err <= 1'b0;
      else if (sample && state == ST_PARITY)
        par_err <= rx_line != parity_bit(shift_q, par_even_q);

      if (start_frame)
        frm_err <= 1'b0;
      else if (sample && (state == ST_STOP1 || state == ST_STOP2) && !rx_line)
        frm_err <= 1'b1;

      // The final stop sample is folded in directly since frm_err only
      // updates on this same edge.
      valid_o         <= complete;
      parity_error_o  <= complete & par_err;
      framing_error_o <= complete & (frm_err | ~rx_line);
      if (complete) data_o <= shift_q;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. A bench-side transmitter
// drives frames; expected characters are queued as each frame is sent and
// compared by a monitor whenever valid_o strobes.
module tb_uart_rx;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        serial_i = 1'b1;
  logic        two_stop_bits_i = 1'b0;
  logic        parity_bit_i = 1'b0;
  logic        parity_even_i = 1'b0;
  logic [15:0] clock_divider_i = 16'd0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        parity_error_o;
  logic        framing_error_o;
  logic        busy_o;

  uart_rx dut (
    .clock_i         (clock_i),
    .reset_ni        (reset_ni),
    .serial_i        (serial_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .clock_divider_i (clock_divider_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .parity_error_o  (parity_error_o),
    .framing_error_o (framing_error_o),
    .busy_o          (busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;
  int   vcount = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  int   busy_rise_cyc = 0;
  int   tx_fall_cyc = 0;
  logic busy_prev = 1'b0;
  bit   busy_seen = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  // Scoreboard monitor: pops one expectation per valid_o cycle; outside
  // valid_o the error outputs must be low.
  always @(negedge clock_i) begin
    if (busy_o === 1'b1 && busy_prev !== 1'b1) begin
      busy_rise_cyc = cyc;
      busy_seen     = 1;
    end
    busy_prev = busy_o;
    checks++;
    if (valid_o === 1'b1) begin
      vcount++;
      last_valid_cyc = cyc;
      if (q.size() == 0) begin
        $display("FAIL unexpected_valid: data_o=%h pe=%b fe=%b, required no valid_o",
                 data_o, parity_error_o, framing_error_o);
      end else begin
        e = q.pop_front();
        if ({data_o, parity_error_o, framing_error_o} !== e)
          $display("FAIL frame: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                   data_o, parity_error_o, framing_error_o, e.data, e.pe, e.fe);
        else passed++;
      end
    end else begin
      if (parity_error_o !== 1'b0 || framing_error_o !== 1'b0)
        $display("FAIL err_without_valid: pe=%b fe=%b, required 0 0",
                 parity_error_o, framing_error_o);
      else passed++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required finish");
    $fatal(1, "watchdog");
  end

  // Parity expectation from a population count.
  function automatic logic exp_par(input logic [7:0] d, input bit even);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return even ? logic'(ones % 2 == 1) : logic'(ones % 2 == 0);
  endfunction

  task automatic cfg(input int div, input bit par, input bit even, input bit two);
    clock_divider_i = 16'(div);
    parity_bit_i    = par;
    parity_even_i   = even;
    two_stop_bits_i = two;
  endtask

  task automatic drive_bit(input logic v, input int n);
    serial_i = v;
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic idle(input int k);
    serial_i = 1'b1;
    repeat (k) @(posedge clock_i);
    #1;
  endtask

  task automatic tx_frame(input logic [7:0] d, input int n, input bit par_en,
                          input logic par_v, input int nstop, input logic stop_v);
    tx_fall_cyc = cyc;
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    if (par_en) drive_bit(par_v, n);
    for (int i = 0; i < nstop; i++) drive_bit(stop_v, n);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clock_i);
      #1;
    end
    if (q.size() == 0) ok = 1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) @(posedge clock_i);
    #1;
    checks++; if (data_o !== 8'h00) $display("FAIL rst_data: got %h, required 00", data_o); else passed++;
    checks++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %b, required 0", valid_o); else passed++;
    checks++; if (parity_error_o !== 1'b0) $display("FAIL rst_pe: got %b, required 0", parity_error_o); else passed++;
    checks++; if (framing_error_o !== 1'b0) $display("FAIL rst_fe: got %b, required 0", framing_error_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy_o); else passed++;
    reset_ni = 1'b1;
    idle(6);
    checks++; if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b, required 0", busy_o); else passed++;
  endtask

  task automatic test_clean();
    int v0;
    bit ok;
    v0 = vcount;
    cfg(1, 1, 1, 1);
    q.push_back('{data: 8'h55, pe: 1'b0, fe: 1'b0});
    tx_frame(8'h55, 2, 1, exp_par(8'h55, 1), 2, 1'b1);
    idle(2);
    wait_drain(60, ok);
    idle(4);
    checks++; if (!ok) $display("FAIL clean_drain: got %0d pending, required 0", q.size()); else passed++;
    checks++; if (vcount !== v0 + 1) $display("FAIL clean_vcount: got %0d, required %0d", vcount - v0, 1); else passed++;
    checks++; if (busy_rise_cyc - tx_fall_cyc !== 3)
      $display("FAIL busy_latency: got %0d, required 3", busy_rise_cyc - tx_fall_cyc); else passed++;
    // 11 bit periods of 2 clocks after the start sample, which sits 4 clocks in.
    checks++; if (last_valid_cyc - tx_fall_cyc !== 26)
      $display("FAIL clean_latency: got %0d, required 26", last_valid_cyc - tx_fall_cyc); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL clean_busy_after: got %b, required 0", busy_o); else passed++;
  endtask

  task automatic test_parity();
    int v0;
    bit ok;
    v0 = vcount;
    cfg(3, 1, 0, 0);
    q.push_back('{data: 8'hA5, pe: 1'b1, fe: 1'b0});
    tx_frame(8'hA5, 4, 1, ~exp_par(8'hA5, 0), 1, 1'b1);
    idle(4);
    q.push_back('{data: 8'hA5, pe: 1'b0, fe: 1'b0});
    tx_frame(8'hA5, 4, 1, exp_par(8'hA5, 0), 1, 1'b1);
    idle(4);
    wait_drain(60, ok);
    checks++; if (!ok) $display("FAIL parity_drain: got %0d pending, required 0", q.size()); else passed++;
    checks++; if (vcount !== v0 + 2) $display("FAIL parity_vcount: got %0d, required 2", vcount - v0); else passed++;
  endtask

  task automatic test_framing();
    int v0;
    bit ok;
    v0 = vcount;
    cfg(7, 0, 0, 0);
    q.push_back('{data: 8'hC3, pe: 1'b0, fe: 1'b1});
    tx_frame(8'hC3, 8, 0, 1'b0, 1, 1'b0);
    repeat (24) @(posedge clock_i);
    #1;
    wait_drain(20, ok);
    checks++; if (!ok) $display("FAIL framing_drain: got %0d pending, required 0", q.size()); else passed++;
    checks++; if (vcount !== v0 + 1) $display("FAIL stuck_low_vcount: got %0d, required 1", vcount - v0); else passed++;
    idle(16);
    q.push_back('{data: 8'h81, pe: 1'b0, fe: 1'b0});
    tx_frame(8'h81, 8, 0, 1'b0, 1, 1'b1);
    idle(8);
    wait_drain(40, ok);
    checks++; if (!ok) $display("FAIL recover_drain: got %0d pending, required 0", q.size()); else passed++;
    checks++; if (vcount !== v0 + 2) $display("FAIL recover_vcount: got %0d, required 2", vcount - v0); else passed++;
  endtask

  task automatic test_false_start();
    int v0;
    v0 = vcount;
    cfg(15, 0, 0, 0);
    busy_seen = 0;
    drive_bit(1'b0, 4);
    idle(30);
    checks++; if (busy_seen !== 1) $display("FAIL glitch_busy_seen: got %0d, required 1", busy_seen); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL glitch_busy_after: got %b, required 0", busy_o); else passed++;
    checks++; if (vcount !== v0) $display("FAIL glitch_vcount: got %0d, required 0", vcount - v0); else passed++;
  endtask

  task automatic test_back_to_back();
    int v0;
    bit ok;
    v0 = vcount;
    cfg(3, 0, 0, 0);
    q.push_back('{data: 8'h00, pe: 1'b0, fe: 1'b0});
    q.push_back('{data: 8'hFF, pe: 1'b0, fe: 1'b0});
    tx_frame(8'h00, 4, 0, 1'b0, 1, 1'b1);
    tx_frame(8'hFF, 4, 0, 1'b0, 1, 1'b1);
    idle(8);
    wait_drain(40, ok);
    checks++; if (!ok) $display("FAIL b2b_drain: got %0d pending, required 0", q.size()); else passed++;
    checks++; if (vcount !== v0 + 2) $display("FAIL b2b_vcount: got %0d, required 2", vcount - v0); else passed++;
    // start sample at 1+4 clocks, stop sample 9 bits of 4 clocks later
    checks++; if (last_valid_cyc - tx_fall_cyc !== 41)
      $display("FAIL b2b_latency: got %0d, required 41", last_valid_cyc - tx_fall_cyc); else passed++;
  endtask

  task automatic test_div_zero();
    int v0;
    bit ok;
    v0 = vcount;
    cfg(0, 0, 0, 0);
    q.push_back('{data: 8'h96, pe: 1'b0, fe: 1'b0});
    tx_frame(8'h96, 2, 0, 1'b0, 1, 1'b1);
    idle(4);
    wait_drain(40, ok);
    checks++; if (!ok) $display("FAIL div0_drain: got %0d pending, required 0", q.size()); else passed++;
    checks++; if (vcount !== v0 + 1) $display("FAIL div0_vcount: got %0d, required 1", vcount - v0); else passed++;
    checks++; if (last_valid_cyc - tx_fall_cyc !== 22)
      $display("FAIL div0_latency: got %0d, required 22", last_valid_cyc - tx_fall_cyc); else passed++;
  endtask

  task automatic test_reset_mid();
    int   v0;
    bit   ok;
    logic [7:0] d;
    v0 = vcount;
    d  = 8'h3C;
    cfg(7, 0, 0, 0);
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    serial_i = d[4];
    repeat (4) @(posedge clock_i);
    #1;
    checks++; if (busy_o !== 1'b1) $display("FAIL mid_busy_before: got %b, required 1", busy_o); else passed++;
    reset_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) $display("FAIL mid_rst_busy: got %b, required 0", busy_o); else passed++;
    checks++; if (data_o !== 8'h00) $display("FAIL mid_rst_data: got %h, required 00", data_o); else passed++;
    checks++; if (valid_o !== 1'b0) $display("FAIL mid_rst_valid: got %b, required 0", valid_o); else passed++;
    repeat (2) @(posedge clock_i);
    #1;
    serial_i = 1'b1;
    reset_ni = 1'b1;
    idle(20);
    checks++; if (vcount !== v0) $display("FAIL mid_abort_vcount: got %0d, required 0", vcount - v0); else passed++;
    q.push_back('{data: 8'h3C, pe: 1'b0, fe: 1'b0});
    tx_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1);
    idle(8);
    wait_drain(40, ok);
    checks++; if (!ok) $display("FAIL mid_next_drain: got %0d pending, required 0", q.size()); else passed++;
    checks++; if (vcount !== v0 + 1) $display("FAIL mid_next_vcount: got %0d, required 1", vcount - v0); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_parity();
    test_framing();
    test_false_start();
    test_back_to_back();
    test_div_zero();
    test_reset_mid();
    idle(4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
